// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins ties until MAX_DATA_RUN back-to-back data grants, then fetch goes once.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_D,
        SERVE_I,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] data_run;
    logic [3:0] run_nxt;
    logic       grant_d;
    logic       grant_i;
    logic       ack_d;
    logic       ack_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            data_run <= '0;
        end else begin
            state    <= state_nxt;
            data_run <= run_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        ack_d     = 1'b0;
        ack_i     = 1'b0;
        run_nxt   = data_run;
        unique case (state)
            IDLE: begin
                if (dm_req && (!if_req || data_run < MAX_RUN)) begin
                    grant_d   = 1'b1;
                    state_nxt = SERVE_D;
                end else if (if_req) begin
                    grant_i   = 1'b1;
                    state_nxt = SERVE_I;
                end
            end
            SERVE_D: begin
                if (mem_ack) begin
                    ack_d     = 1'b1;
                    state_nxt = DONE;
                end
            end
            SERVE_I: begin
                if (mem_ack) begin
                    ack_i     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // The run only counts data grants that actually made fetch wait.
        if (grant_d) begin
            if (!if_req)
                run_nxt = '0;
            else if (data_run >= MAX_RUN)
                run_nxt = MAX_RUN;
            else
                run_nxt = data_run + 4'd1;
        end
        if (grant_i)
            run_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
        end else begin
            if_ready <= ack_i;
            dm_ready <= ack_d;
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                mem_be    <= dm_be;
            end
            if (grant_i) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_be    <= {BE_W{1'b1}};
            end
            if (ack_d || ack_i)
                mem_req <= 1'b0;
            if (ack_i)
                if_rdata <= mem_rdata;
            if (ack_d && !mem_we)
                dm_rdata <= mem_rdata;
        end
    end

    assign busy = (state != IDLE);

endmodule
